ldsd_decoder: RTL and testbench

- Decodes a stream of 32-bit RISC-V instruction words into load/store fields.
- Sits between instruction memory (or a bench driver) and the datapath/trace logic.
- Also runs a ld->sd pairing checker and saturating event counters.
- Registered output with a valid/ready handshake on both sides. Latency is 1 cycle.

---
 rtl/ldsd_decoder.sv | 151 +++++++++++++++
 tb/tb_ldsd_decoder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ldsd_decoder.sv
// rtl/ldsd_decoder.sv - RISC-V ld/sd field decoder with pairing checker and event counters
module ldsd_decoder #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_kind,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic [31:0]      out_instr,
    output logic             pair_ok,
    output logic             pair_err,
    output logic [CNT_W-1:0] ld_cnt,
    output logic [CNT_W-1:0] sd_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0] K_OTHER = 2'd0;
    localparam logic [1:0] K_LD    = 2'd1;
    localparam logic [1:0] K_SD    = 2'd2;
    localparam logic [1:0] K_BADW  = 2'd3;

    typedef enum logic {S_IDLE, S_LD} state_t;

    state_t          state_q, state_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic            pair_ok_d, pair_err_d;
    logic            accept;
    logic [1:0]      d_kind;
    logic [4:0]      d_rd, d_rs2;
    logic [11:0]     d_imm12;
    logic [XLEN-1:0] d_imm;
    logic            is_load_op, is_store_op, is_dword;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign is_load_op  = (in_instr[6:0] == 7'b0000011);
    assign is_store_op = (in_instr[6:0] == 7'b0100011);
    assign is_dword    = (in_instr[14:12] == 3'b011);

    // Classify the incoming word and extract its fields
    always_comb begin
        d_kind  = K_OTHER;
        d_imm12 = 12'd0;
        if (is_load_op) begin
            d_kind  = is_dword ? K_LD : K_BADW;
            d_imm12 = in_instr[31:20];
        end else if (is_store_op) begin
            d_kind  = is_dword ? K_SD : K_BADW;
            d_imm12 = {in_instr[31:25], in_instr[11:7]};
        end
        d_rd  = (d_kind == K_SD) ? 5'd0 : in_instr[11:7];
        d_rs2 = (d_kind == K_LD) ? 5'd0 : in_instr[24:20];
        d_imm = (d_kind == K_OTHER) ? '0 : {{(XLEN-12){d_imm12[11]}}, d_imm12};
    end

    // Output beat register: load on accept, drop on pop without a replacement
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_kind  <= 2'd0;
            out_rd    <= 5'd0;
            out_rs1   <= 5'd0;
            out_rs2   <= 5'd0;
            out_imm   <= '0;
            out_instr <= 32'd0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_kind  <= d_kind;
            out_rd    <= d_rd;
            out_rs1   <= in_instr[19:15];
            out_rs2   <= d_rs2;
            out_imm   <= d_imm;
            out_instr <= in_instr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Pairing FSM state, latched ld destination and registered pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ld_rd_q  <= 5'd0;
            pair_ok  <= 1'b0;
            pair_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_rd_q  <= ld_rd_d;
            pair_ok  <= pair_ok_d;
            pair_err <= pair_err_d;
        end
    end

    // Pairing next-state: only an accepted word moves the FSM
    always_comb begin
        state_d    = state_q;
        ld_rd_d    = ld_rd_q;
        pair_ok_d  = 1'b0;
        pair_err_d = 1'b0;
        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (d_kind == K_LD) begin
                        ld_rd_d = in_instr[11:7];
                        state_d = S_LD;
                    end
                end
                S_LD: begin
                    if (d_kind == K_LD) begin
                        ld_rd_d = in_instr[11:7];
                        state_d = S_LD;
                    end else begin
                        state_d = S_IDLE;
                        if (d_kind == K_SD) begin
                            pair_ok_d  = (in_instr[24:20] == ld_rd_q);
                            pair_err_d = (in_instr[24:20] != ld_rd_q);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Saturating event counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ld_cnt  <= '0;
            sd_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (accept && d_kind == K_LD && ld_cnt != '1)
                ld_cnt <= ld_cnt + 1'b1;
            if (accept && d_kind == K_SD && sd_cnt != '1)
                sd_cnt <= sd_cnt + 1'b1;
            if (accept && (d_kind == K_BADW || pair_err_d) && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ldsd_decoder.sv
// tb/tb_ldsd_decoder.sv - directed-vector bench for ldsd_decoder
module tb_ldsd_decoder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_kind;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [63:0] out_imm;
    logic [31:0] out_instr;
    logic        pair_ok, pair_err;
    logic [15:0] ld_cnt, sd_cnt, err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] LD_X1   = 32'h0040_3083;
    localparam logic [31:0] SD_OK   = 32'h001F_B023;
    localparam logic [31:0] SD_BAD  = 32'hFE21_BC23;
    localparam logic [31:0] LW_X1   = 32'h0040_2083;
    localparam logic [31:0] ADDI    = 32'h0000_0013;

    ldsd_decoder #(.XLEN(64), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_instr(out_instr),
        .pair_ok(pair_ok), .pair_err(pair_err),
        .ld_cnt(ld_cnt), .sd_cnt(sd_cnt), .err_cnt(err_cnt)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_cmp++; if ({ld_cnt, sd_cnt, err_cnt} !== 48'd0) begin n_bad++; $display("FAIL reset_counters got %0h/%0h/%0h want 0", ld_cnt, sd_cnt, err_cnt); end
        n_cmp++; if ({pair_ok, pair_err, out_kind} !== 4'd0) begin n_bad++; $display("FAIL reset_pulses_kind got %0b%0b %0d want 0", pair_ok, pair_err, out_kind); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_ld_sd_pair_ok();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = LD_X1;
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ld_valid got %0b want 1", out_valid); end
        n_cmp++; if ({out_kind, out_rd, out_rs1, out_rs2} !== {2'd1, 5'd1, 5'd0, 5'd0}) begin n_bad++; $display("FAIL ld_fields got k%0d rd%0d rs1%0d rs2%0d want k1 rd1 rs1 0 rs2 0", out_kind, out_rd, out_rs1, out_rs2); end
        n_cmp++; if (out_imm !== 64'd4) begin n_bad++; $display("FAIL ld_imm got %0h want 4", out_imm); end
        n_cmp++; if (ld_cnt !== 16'd1) begin n_bad++; $display("FAIL ld_cnt1 got %0d want 1", ld_cnt); end
        in_instr = SD_OK;
        step();
        n_cmp++; if ({out_kind, out_rd, out_rs1, out_rs2} !== {2'd2, 5'd0, 5'd31, 5'd1}) begin n_bad++; $display("FAIL sd_fields got k%0d rd%0d rs1%0d rs2%0d want k2 rd0 rs1 31 rs2 1", out_kind, out_rd, out_rs1, out_rs2); end
        n_cmp++; if (out_imm !== 64'd0) begin n_bad++; $display("FAIL sd_imm got %0h want 0", out_imm); end
        n_cmp++; if ({pair_ok, pair_err} !== 2'b10) begin n_bad++; $display("FAIL pair_ok_pulse got ok%0b err%0b want ok1 err0", pair_ok, pair_err); end
        n_cmp++; if (sd_cnt !== 16'd1 || out_instr !== SD_OK) begin n_bad++; $display("FAIL sd_cnt_instr got %0d %0h want 1 %0h", sd_cnt, out_instr, SD_OK); end
        in_valid = 1'b0;
        step();
        n_cmp++; if ({out_valid, pair_ok, pair_err} !== 3'b000) begin n_bad++; $display("FAIL drain got v%0b ok%0b err%0b want 000", out_valid, pair_ok, pair_err); end
    endtask

    task automatic test_pair_err();
        in_valid = 1'b1; in_instr = LD_X1;
        step();
        in_instr = SD_BAD;
        step();
        n_cmp++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_bad++; $display("FAIL sd_neg_imm got %0h want fffffffffffffff8", out_imm); end
        n_cmp++; if ({out_rs1, out_rs2} !== {5'd3, 5'd2}) begin n_bad++; $display("FAIL sd_bad_regs got rs1 %0d rs2 %0d want 3 2", out_rs1, out_rs2); end
        n_cmp++; if ({pair_ok, pair_err} !== 2'b01) begin n_bad++; $display("FAIL pair_err_pulse got ok%0b err%0b want ok0 err1", pair_ok, pair_err); end
        n_cmp++; if ({ld_cnt, sd_cnt, err_cnt} !== {16'd2, 16'd2, 16'd1}) begin n_bad++; $display("FAIL cnt_after_err got %0d/%0d/%0d want 2/2/1", ld_cnt, sd_cnt, err_cnt); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (pair_err !== 1'b0) begin n_bad++; $display("FAIL pair_err_one_cycle got %0b want 0", pair_err); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_instr = LD_X1; out_ready = 1'b0;
        step();
        in_instr = ADDI;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({out_valid, in_ready} !== 2'b10 || out_instr !== LD_X1 || out_kind !== 2'd1) begin n_bad++; $display("FAIL hold_%0d got v%0b rdy%0b instr %0h kind %0d want v1 rdy0 %0h kind 1", i, out_valid, in_ready, out_instr, out_kind, LD_X1); end
            step();
        end
        out_ready = 1'b1; in_instr = SD_OK;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_instr !== SD_OK || pair_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_sd got v%0b %0h ok%0b want v1 %0h ok1", out_valid, out_instr, pair_ok, SD_OK); end
        n_cmp++; if ({ld_cnt, sd_cnt} !== {16'd3, 16'd3}) begin n_bad++; $display("FAIL b2b_cnt got %0d/%0d want 3/3", ld_cnt, sd_cnt); end
        in_instr = LW_X1;
        step();
        n_cmp++; if ({out_valid, out_kind, out_rd} !== {1'b1, 2'd3, 5'd1} || out_imm !== 64'd4) begin n_bad++; $display("FAIL badw got v%0b k%0d rd%0d imm %0h want v1 k3 rd1 imm 4", out_valid, out_kind, out_rd, out_imm); end
        n_cmp++; if (err_cnt !== 16'd2 || pair_ok !== 1'b0) begin n_bad++; $display("FAIL badw_err got err%0d ok%0b want 2 0", err_cnt, pair_ok); end
        in_instr = SD_OK;
        step();
        n_cmp++; if ({pair_ok, pair_err} !== 2'b00 || out_kind !== 2'd2) begin n_bad++; $display("FAIL idle_after_badw got ok%0b err%0b k%0d want 0 0 2", pair_ok, pair_err, out_kind); end
        n_cmp++; if ({sd_cnt, err_cnt} !== {16'd4, 16'd2}) begin n_bad++; $display("FAIL idle_cnt got %0d/%0d want 4/2", sd_cnt, err_cnt); end
        in_instr = ADDI;
        step();
        n_cmp++; if ({out_kind, out_rd, out_rs2} !== 12'd0 || out_imm !== 64'd0) begin n_bad++; $display("FAIL other got k%0d rd%0d rs2%0d imm %0h want all 0", out_kind, out_rd, out_rs2, out_imm); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_saturate_and_reset();
        in_valid = 1'b1; in_instr = LD_X1; out_ready = 1'b1;
        repeat (65532) step();
        n_cmp++; if (ld_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL ld_reach_max got %0h want ffff", ld_cnt); end
        step();
        n_cmp++; if (ld_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL ld_saturate got %0h want ffff", ld_cnt); end
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL prehold got %0b want 1", out_valid); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || {ld_cnt, sd_cnt, err_cnt} !== 48'd0) begin n_bad++; $display("FAIL async_reset got v%0b %0h/%0h/%0h want 0", out_valid, ld_cnt, sd_cnt, err_cnt); end
        step();
        reset = 1'b0; out_ready = 1'b1;
        step();
        in_valid = 1'b1; in_instr = SD_OK;
        step();
        n_cmp++; if ({out_valid, out_kind, pair_ok, pair_err} !== {1'b1, 2'd2, 2'b00} || sd_cnt !== 16'd1) begin n_bad++; $display("FAIL post_reset got v%0b k%0d ok%0b err%0b sd%0d want v1 k2 0 0 sd1", out_valid, out_kind, pair_ok, pair_err, sd_cnt); end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_ld_sd_pair_ok();
        test_pair_err();
        test_back_to_back();
        test_saturate_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
